// File: rtl/cordic_pkg.sv
// Shared types and fixed-point constants for the shared-CORDIC cosine scheduler.
package cordic_pkg;

    typedef logic [23:0] fx_t;
    typedef logic [31:0] ft_t;

    localparam int  FX_FRAC = 22;
    localparam fx_t FX_ONE  = 24'h40_0000;

    typedef struct packed {
        logic       v;
        logic [2:0] id;
    } tag_t;

endpackage

// File: rtl/ft_to_fx.sv
// float32 -> signed Q2.22, truncating toward zero and saturating when |x| >= 2.0.
module ft_to_fx
    import cordic_pkg::*;
(
    input  logic [31:0] f,
    output logic [23:0] x
);

    logic       sgn;
    logic [7:0] e;
    fx_t        mant;
    fx_t        mag;

    // Q2.22 value = mant * 2^(e-128); exponents below 105 shift everything out.
    always_comb begin
        sgn  = f[31];
        e    = f[30:23];
        mant = {1'b1, f[22:0]};
        mag  = '0;
        x    = '0;
        if (e >= 8'd128) begin
            x = sgn ? 24'h80_0000 : 24'h7F_FFFF;
        end else if (e > 8'd104) begin
            mag = mant >> (8'd128 - e);
            x   = sgn ? (~mag + 24'd1) : mag;
        end
    end

endmodule

// File: rtl/fx_to_ft.sv
// signed Q2.22 -> float32; exact because the magnitude never exceeds 24 bits.
module fx_to_ft
    import cordic_pkg::*;
(
    input  logic [23:0] x,
    output logic [31:0] f
);

    logic       sgn;
    fx_t        mag;
    fx_t        norm;
    logic [4:0] msb;

    always_comb begin
        sgn  = x[23];
        mag  = sgn ? (~x + 24'd1) : x;
        msb  = '0;
        for (int i = 0; i < 24; i++) begin
            if (mag[i]) begin
                msb = 5'(i);
            end
        end
        norm = mag << (5'd23 - msb);
        f    = '0;
        if (mag != '0) begin
            f = {sgn, 8'(msb) + 8'(127 - FX_FRAC), norm[22:0]};
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant starting the search at ptr.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] next_ptr
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    // Walk from the farthest candidate back to ptr so the closest eligible one wins.
    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        sum      = '0;
        idx      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (PW + 1)'(k);
            if (sum >= (PW + 1)'(N)) begin
                sum = sum - (PW + 1)'(N);
            end
            idx = sum[PW-1:0];
            if (eligible[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                next_ptr   = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cordic_cos_sched.sv
// Round-robin scheduler sharing one external cordic_ip cosine pipe among NREQ float32 requesters.
// Optional perf counters are built when CORDIC_PERF_EN is defined; otherwise both read zero.
module cordic_cos_sched
    import cordic_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int CORDIC_LAT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*32-1:0] req_data,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [NREQ*32-1:0] rsp_data,
    output logic [23:0]       cordic_z,
    input  logic [23:0]       cordic_cos,
    output logic [31:0]       perf_busy,
    output logic [31:0]       perf_ops
);

    localparam int PW = $clog2(NREQ);

    logic [NREQ-1:0] outstanding_reg;
    logic [NREQ-1:0] rsp_valid_reg;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] fire;
    logic [NREQ-1:0] set_valid;
    logic [PW-1:0]   ptr_reg;
    logic [PW-1:0]   ptr_next;
    logic [2:0]      grant_id;
    ft_t             grant_data;
    fx_t             grant_fx;
    fx_t             z_reg;
    tag_t            tag_reg [CORDIC_LAT+1];
    logic            cap_v_reg;
    logic [2:0]      cap_id_reg;
    fx_t             cap_cos_reg;
    ft_t             cap_ft;
    ft_t             slot_reg [NREQ];

    // A requester with an op in flight stays ineligible until its result is consumed.
    assign eligible  = req_valid & ~outstanding_reg;
    assign req_ready = grant;
    assign fire      = rsp_valid_reg & rsp_ready;
    assign rsp_valid = rsp_valid_reg;
    assign cordic_z  = z_reg;

    rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
        .eligible (eligible),
        .ptr      (ptr_reg),
        .grant    (grant),
        .next_ptr (ptr_next)
    );

    always_comb begin
        grant_id   = '0;
        grant_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_id   = 3'(i);
                grant_data = req_data[32*i +: 32];
            end
        end
    end

    ft_to_fx u_ft_to_fx (.f(grant_data), .x(grant_fx));
    fx_to_ft u_fx_to_ft (.x(cap_cos_reg), .f(cap_ft));

    // The exit tag samples cordic_cos into a capture register; conversion happens the cycle after.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_reg         <= '0;
            outstanding_reg <= '0;
            z_reg           <= '0;
            cap_v_reg       <= 1'b0;
            cap_id_reg      <= '0;
            cap_cos_reg     <= '0;
            rsp_valid_reg   <= '0;
            for (int k = 0; k <= CORDIC_LAT; k++) begin
                tag_reg[k] <= '0;
            end
        end else begin
            if (|grant) begin
                ptr_reg <= ptr_next;
                z_reg   <= grant_fx;
            end
            outstanding_reg <= (outstanding_reg & ~fire) | grant;
            tag_reg[0]      <= {|grant, grant_id};
            for (int k = 1; k <= CORDIC_LAT; k++) begin
                tag_reg[k] <= tag_reg[k-1];
            end
            cap_v_reg     <= tag_reg[CORDIC_LAT].v;
            cap_id_reg    <= tag_reg[CORDIC_LAT].id;
            cap_cos_reg   <= cordic_cos;
            rsp_valid_reg <= (rsp_valid_reg & ~fire) | set_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREQ; i++) begin
                slot_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (set_valid[i]) begin
                    slot_reg[i] <= cap_ft;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
            assign set_valid[gi]          = cap_v_reg && (cap_id_reg == 3'(gi));
            assign rsp_data[32*gi +: 32] = slot_reg[gi];
        end
    endgenerate

`ifdef CORDIC_PERF_EN
    logic [31:0] perf_busy_reg;
    logic [31:0] perf_ops_reg;
    logic [31:0] fire_cnt;

    always_comb begin
        fire_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            fire_cnt = fire_cnt + 32'(fire[i]);
        end
    end

    // Busy saturates; the op count is allowed to wrap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_busy_reg <= '0;
            perf_ops_reg  <= '0;
        end else begin
            if ((|outstanding_reg) && (perf_busy_reg != 32'hFFFF_FFFF)) begin
                perf_busy_reg <= perf_busy_reg + 32'd1;
            end
            perf_ops_reg <= perf_ops_reg + fire_cnt;
        end
    end

    assign perf_busy = perf_busy_reg;
    assign perf_ops  = perf_ops_reg;
`else
    assign perf_busy = '0;
    assign perf_ops  = '0;
`endif

endmodule

// File: tb/tb_cordic_cos_sched.sv
// Directed bench for cordic_cos_sched with a behavioural 4-stage cordic_ip stand-in.
`timescale 1ns/1ps
module tb_cordic_cos_sched;
    import cordic_pkg::*;

    localparam int NREQ = 4;
    localparam int LAT  = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*32-1:0] req_data = '0;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready = '0;
    logic [NREQ*32-1:0] rsp_data;
    logic [23:0]       cordic_z;
    logic [23:0]       cordic_cos;
    logic [31:0]       perf_busy;
    logic [31:0]       perf_ops;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cordic_cos_sched #(.NREQ(NREQ), .CORDIC_LAT(LAT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .cordic_z   (cordic_z),
        .cordic_cos (cordic_cos),
        .perf_busy  (perf_busy),
        .perf_ops   (perf_ops)
    );

    // cordic_ip stand-in: cos of cordic_z, rounded to Q2.22, LAT cycles later.
    fx_t zd [LAT];
    always @(posedge clk) begin
        zd[0] <= cordic_z;
        for (int k = 1; k < LAT; k++) begin
            zd[k] <= zd[k-1];
        end
    end

    function automatic fx_t cos_model(input fx_t z);
        real a;
        real c;
        a = $itor($signed(z)) / 4194304.0;
        c = $cos(a);
        return fx_t'($rtoi(c * 4194304.0 + ((c < 0.0) ? -0.5 : 0.5)));
    endfunction

    assign cordic_cos = cos_model(zd[LAT-1]);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One request on requester id; returns result and edges from accept to rsp_valid.
    task automatic single(input logic [1:0] id, input logic [31:0] ang,
                          output logic [31:0] res, output int lat);
        req_data[32*id +: 32] = ang;
        req_valid[id] = 1'b1;
        #1;
        check_eq("single_ready", 32'(req_ready), 32'(4'b0001 << id));
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
        lat = 0;
        while (!rsp_valid[id] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = rsp_data[32*id +: 32];
        $display("txn req%0d angle=%h result=%h latency=%0d", id, ang, res, lat);
        rsp_ready[id] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[id] = 1'b0;
        check_eq("single_clear", 32'(rsp_valid[id]), 32'd0);
    endtask

    logic [31:0] res;
    int          lat;
    int          n_bad;
    int          cnt [NREQ];
    logic [31:0] exp3 [4];

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp3[0] = 32'h3F80_0000;
        exp3[1] = 32'h3F60_A940;
        exp3[2] = 32'h3F0A_5140;
        exp3[3] = 32'h3F0A_5140;

        // Reset state
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_cordic_z", 32'(cordic_z), 32'd0);
        check_eq("rst_rsp_data0", rsp_data[31:0], 32'd0);
        check_eq("rst_perf_busy", perf_busy, 32'd0);
        check_eq("rst_perf_ops", perf_ops, 32'd0);
        reset_n = 1'b1;

        // cos(0) = 1.0, latency accept+6
        single(2'd0, 32'h0000_0000, res, lat);
        check_eq("zero_latency", 32'(lat), 32'd6);
        check_eq("zero_result", res, 32'h3F80_0000);

        // cos(pi/2) ~ 0
        single(2'd0, 32'h3FC9_0FDB, res, lat);
        check_eq("pi2_latency", 32'(lat), 32'd6);
        check_eq("pi2_small", 32'((res & 32'h7FFF_FFFF) < 32'h3680_0000), 32'd1);

        // pi is out of Q2.22 range but must still be delivered
        single(2'd1, 32'h4049_0FDB, res, lat);
        check_eq("pi_delivered", 32'(lat), 32'd6);

        // Reset with ops in flight: nothing may come back
        req_data  = '0;
        req_valid = 4'b1110;
        repeat (3) @(posedge clk);
        #1;
        check_eq("inflight_no_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        reset_n   = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_eq("rst2_perf_ops", perf_ops, 32'd0);
        n_bad = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (rsp_valid != '0) n_bad++;
        end
        check_eq("rst2_no_rsp", 32'(n_bad), 32'd0);

        // All four at once from ptr=0: grants and responses 0,1,2,3
        req_data  = {32'hBF80_0000, 32'h3F80_0000, 32'h3F00_0000, 32'h0000_0000};
        rsp_ready = 4'b1111;
        req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("burst_grant", 32'(req_ready), 32'(4'b0001 << k));
            @(posedge clk);
        end
        #1;
        req_valid = '0;
        for (int c = 4; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (c >= 6) begin
                $display("txn req%0d result=%h", c - 6, rsp_data[32*(c-6) +: 32]);
                check_eq("burst_rsp_valid", 32'(rsp_valid), 32'(4'b0001 << (c - 6)));
                check_eq("burst_rsp_data", rsp_data[32*(c-6) +: 32], exp3[c-6]);
            end
        end
        repeat (2) @(posedge clk);
        #1;

        // Backpressure on requester 2
        req_data  = {32'h0000_0000, 32'h3F80_0000, 32'h0000_0000, 32'h0000_0000};
        rsp_ready = 4'b1011;
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) cnt[i] = 0;
        n_bad = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) cnt[i]++;
            end
            if (k >= 9 && (rsp_valid[2] !== 1'b1 || rsp_data[95:64] !== 32'h3F0A_5140)) n_bad++;
            @(posedge clk);
        end
        #1;
        req_valid = '0;
        rsp_ready = 4'b1111;
        $display("txn backpressure grants=%0d/%0d/%0d/%0d", cnt[0], cnt[1], cnt[2], cnt[3]);
        check_eq("bp_grants0", 32'(cnt[0]), 32'd3);
        check_eq("bp_grants1", 32'(cnt[1]), 32'd3);
        check_eq("bp_grants2", 32'(cnt[2]), 32'd1);
        check_eq("bp_grants3", 32'(cnt[3]), 32'd3);
        check_eq("bp_hold", 32'(n_bad), 32'd0);
        @(posedge clk);
        #1;
        check_eq("bp_released", 32'(rsp_valid[2]), 32'd0);
        repeat (12) @(posedge clk);
        #1;
        check_eq("drain_idle", 32'(rsp_valid), 32'd0);

`ifdef CORDIC_PERF_EN
        check_eq("perf_ops", perf_ops, 32'd14);
        check_eq("perf_busy_min", 32'(perf_busy >= 32'd14), 32'd1);
`else
        check_eq("perf_ops_off", perf_ops, 32'd0);
        check_eq("perf_busy_off", perf_busy, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
